// File: rtl/mgt_01_freg_wb_arbiter_pkg.sv
// Shared types and constants for the MicroGT-01 FP register-file write-back path.
// f_register_e and float_t follow the core's existing FP register index and
// IEEE-754 single-precision word layout.
package mgt_01_freg_wb_arbiter_pkg;

  typedef logic [4:0]  f_register_e;
  typedef logic [31:0] float_t;

  // Write-back requester order; the index is also the arbiter request bit.
  typedef enum logic [1:0] {
    WB_FPU = 2'd0,
    WB_LSU = 2'd1,
    WB_MOV = 2'd2
  } fp_wb_src_e;

  localparam int FREG_WB_NREQ = 3;
  localparam int FREG_NUM     = 32;

endpackage

// File: rtl/mgt_01_freg_wb_arbiter_rr.sv
// Generic NREQ-way round-robin arbiter. Purely combinational: the caller owns
// the pointer register and advances it after an accepted grant.
module MGT_01_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand_s;

  // Pointer plus offset, wrapped into 0..NREQ-1 (pointer is always < NREQ).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NREQ) ? (sum - NREQ) : sum;
    return sum[IW-1:0];
  endfunction

  // Scan from the pointer upward and grant the first requester found.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = wrap_add(ptr_i, off);
      if (!any_o && req_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
        any_o         = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mgt_01_freg_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the MicroGT-01 FP
// register file. Round-robin shares the single write port between FPU, LSU
// and MOV; the winning write is registered one cycle before the file.
// Optional feature macro: FREG_SCOREBOARD_EN builds the busy_q scoreboard and
// RAW/WAW hazard stall; without it the stall only reflects lock_i.
module mgt_01_freg_wb_arbiter
  import mgt_01_freg_wb_arbiter_pkg::*;
#(
  parameter int NREQ = FREG_WB_NREQ
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          wb_valid_i,
  input  f_register_e [NREQ-1:0]   wb_faddr_i,
  input  float_t [NREQ-1:0]        wb_fdata_i,
  output logic [NREQ-1:0]          wb_ready_o,
  input  logic                     lock_i,
  output logic                     we_o,
  output f_register_e              wr_faddr_o,
  output float_t                   wr_fdata_o,
  input  logic                     issue_valid_i,
  input  f_register_e              issue_fdst_i,
  input  f_register_e [2:0]        issue_fsrc_i,
  output logic                     issue_stall_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_q, rr_d;
  logic            we_q;
  f_register_e     wr_faddr_q, wr_faddr_d;
  float_t          wr_fdata_q, wr_fdata_d;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   gidx_s;
  logic            gany_s;
  logic            accept_s;
  logic            issue_stall_s;

  MGT_01_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i (wb_valid_i),
    .ptr_i (rr_q),
    .gnt_o (gnt_s),
    .idx_o (gidx_s),
    .any_o (gany_s)
  );

  // lock_i masks every grant in the same cycle; a grant is accepted as soon as it is shown.
  always_comb begin
    if (lock_i) begin
      wb_ready_o = '0;
      accept_s   = 1'b0;
    end else begin
      wb_ready_o = gnt_s;
      accept_s   = gany_s;
    end
  end

  // Next pointer and write-register contents; address/data hold when nothing is accepted.
  always_comb begin
    rr_d       = rr_q;
    wr_faddr_d = wr_faddr_q;
    wr_fdata_d = wr_fdata_q;
    if (accept_s) begin
      rr_d       = (gidx_s == IW'(NREQ - 1)) ? '0 : (gidx_s + IW'(1));
      wr_faddr_d = wb_faddr_i[gidx_s];
      wr_fdata_d = wb_fdata_i[gidx_s];
    end else begin
      rr_d = rr_q;
    end
  end

  // Arbitration pointer and the registered register-file write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      we_q       <= 1'b0;
      wr_faddr_q <= '0;
      wr_fdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      we_q       <= accept_s;
      wr_faddr_q <= wr_faddr_d;
      wr_fdata_q <= wr_fdata_d;
    end
  end

`ifdef FREG_SCOREBOARD_EN
  logic [FREG_NUM-1:0] busy_q, busy_d;
  logic                hazard_s;

  // Any operand or the destination still waiting on a write is a hazard.
  always_comb begin
    hazard_s = busy_q[issue_fdst_i]    | busy_q[issue_fsrc_i[0]] |
               busy_q[issue_fsrc_i[1]] | busy_q[issue_fsrc_i[2]];
    issue_stall_s = issue_valid_i & (hazard_s | lock_i);
  end

  // Clear on the write the file captures, then set on issue so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[wr_faddr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_valid_i && !issue_stall_s) begin
      busy_d[issue_fdst_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Pending-write scoreboard storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_issue_regs_s;

  // Without the scoreboard only a save/restore lock holds issue back.
  always_comb begin
    issue_stall_s = issue_valid_i & lock_i;
  end

  assign unused_issue_regs_s = ^{issue_fdst_i, issue_fsrc_i};
`endif

  assign we_o          = we_q;
  assign wr_faddr_o    = wr_faddr_q;
  assign wr_fdata_o    = wr_fdata_q;
  assign issue_stall_o = issue_stall_s;

endmodule
